blink_rate_controller: RTL
==========================

Name: blink_rate_controller

Overview:
- Single shared divider that replaces one-counter-per-rate blinking. Generates a square wave at one of three selectable rates (10 Hz, 1 Hz, 0.1 Hz at 50 MHz), or off.
- A 4-state mode FSM selects the rate. It is stepped by a push-button (sync + edge-detect) or loaded directly.
- Sits between board switches/keys and an LEDR output in the DE10-Lite top level.

Parameters:
- CNT_W, 28, counter width; must hold the largest modulus.
- K_10HZ, 2_500_000, half-period in clock cycles for the 10 Hz mode.
- K_1HZ, 25_000_000, half-period for the 1 Hz mode.
- K_0HZ1, 250_000_000, half-period for the 0.1 Hz mode.
- INIT_MODE, 2'd1, mode loaded on reset.

Ports:
- i_clk  in  1  system clock (50 MHz).
- i_reset_n  in  1  asynchronous, active-low reset.
- i_step  in  1  raw button level, asynchronous, active-high.
- i_pause  in  1  synchronous; high freezes the counter and outputs.
- i_mode_load  in  1  synchronous; high loads i_mode_val this cycle.
- i_mode_val  in  2  mode to load.
- o_clk  out  1  divided square wave.
- o_tick  out  1  one-cycle pulse on every o_clk toggle.
- o_mode  out  2  current mode.

Behaviour:
- Reset (async, i_reset_n=0):
  - mode=INIT_MODE, count=0, o_clk=0, o_tick=0.
  - Sync flops cleared. Takes effect immediately, not at a clock edge.
- Mode encoding: 0 OFF, 1 10 Hz, 2 1 Hz, 3 0.1 Hz. Modulus K = K_10HZ, K_1HZ or K_0HZ1 per mode.
- Step path:
  - i_step passes through a 2-flop synchronizer, then a rising-edge detector.
  - Mode advances at the 3rd rising edge of i_clk at which i_step is sampled high.
  - Exactly one advance per press, regardless of hold length.
  - Advance sequence is 0→1→2→3→0 (wraps).
- Load/step priority:
  - i_mode_load has priority over a step pulse in the same cycle; that step pulse is discarded.
  - Load of a value equal to the current mode still counts as a mode change (resync).
- Mode change (step or load), at the same edge:
  - count←0, o_clk←0, o_tick←0.
  - This applies even while i_pause=1.
- Counting, per edge with mode≠OFF, i_pause=0, no mode change:
  - If count==K-1: count←0, o_clk←~o_clk, o_tick←1.
  - Else: count←count+1, o_tick←0.
  - Resulting o_clk period is 2K cycles; o_tick is registered (no combinational path).
  - With these rules the first o_tick after reset or a mode change appears after edge K.
- Pause: when i_pause=1, count and o_clk hold and o_tick←0. Counting resumes from the held count.
- Mode OFF: count held at 0, o_clk=0, o_tick=0.
- Width rules:
  - Comparison uses K-1 truncated to CNT_W.
  - Each K must satisfy 1 ≤ K ≤ 2^CNT_W; an elaboration-time assertion enforces this.
  - K=1 toggles o_clk every cycle.
- o_mode is registered and equals the mode register.

Decomposition:
- Package clocks_pkg holds:
  - typedef enum logic [1:0] rate_mode_t {MODE_OFF, MODE_10HZ, MODE_1HZ, MODE_0HZ1};
  - localparam CLK_HZ = 50_000_000.
- Sub-module step_sync_edge contains the 2-flop synchronizer plus the edge detector. It uses the same clock and async active-low reset, and outputs a 1-cycle pulse.
- Counter, mode FSM and modulus mux stay in blink_rate_controller.

Test Plan:
All scenarios use bench parameters K_10HZ=4, K_1HZ=10, K_0HZ1=25, INIT_MODE=1, CNT_W=8.
1. Release reset, idle inputs:
   - o_mode=1.
   - o_tick high after edges 4, 8, 12, …
   - o_clk toggles at those edges (period 8 cycles), starting at 0.
2. i_step high for 6 cycles (starting mode 1):
   - o_mode becomes 2 at the 3rd edge, once only.
   - o_clk forced to 0 and count cleared.
   - Next o_tick exactly 10 edges later.
3. Step from mode 3:
   - o_mode=0.
   - o_clk=0 and o_tick=0 for 100 cycles.
   - A further step gives o_mode=1, first tick 4 edges later.
4. Load and step together: i_mode_load=1, i_mode_val=3 in the same cycle as the edge-detected step pulse.
   - o_mode=3, not 2; no second advance follows.
5. Pause, mode 1: i_pause=1 for 7 cycles when count=2.
   - o_clk and count frozen, no o_tick during the pause.
   - Next tick lands 7 cycles later than unpaused.
6. Async reset mid-count: pull i_reset_n low between clock edges.
   - o_clk, o_tick and count go to 0, o_mode=1, immediately without a clock edge.
   - Counting restarts cleanly after release.

Source files
------------

// File: rtl/clocks_pkg.sv
// Shared types and constants for the board clocking/blink blocks.
package clocks_pkg;

    localparam int unsigned CLK_HZ = 50_000_000;

    typedef enum logic [1:0] {
        MODE_OFF,
        MODE_10HZ,
        MODE_1HZ,
        MODE_0HZ1
    } rate_mode_t;

    function automatic rate_mode_t next_mode(input rate_mode_t mode);
        rate_mode_t nxt;
        unique case (mode)
            MODE_OFF:  nxt = MODE_10HZ;
            MODE_10HZ: nxt = MODE_1HZ;
            MODE_1HZ:  nxt = MODE_0HZ1;
            MODE_0HZ1: nxt = MODE_OFF;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/step_sync_edge.sv
// Two-flop synchronizer for an asynchronous button, followed by a rising-edge
// detector producing a single-cycle pulse per press.
module step_sync_edge (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_step,
    output logic o_pulse
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= i_step;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign o_pulse = r_sync2 & ~r_prev;

endmodule

// File: rtl/blink_rate_controller.sv
// Shared divider producing a square wave at one of three rates (or off),
// with the rate chosen by a 4-state mode FSM stepped by a button or loaded.
module blink_rate_controller
    import clocks_pkg::*;
#(
    parameter int unsigned CNT_W     = 28,
    parameter int unsigned K_10HZ    = 2_500_000,
    parameter int unsigned K_1HZ     = 25_000_000,
    parameter int unsigned K_0HZ1    = 250_000_000,
    parameter logic [1:0]  INIT_MODE = 2'd1
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_step,
    input  logic       i_pause,
    input  logic       i_mode_load,
    input  logic [1:0] i_mode_val,
    output logic       o_clk,
    output logic       o_tick,
    output logic [1:0] o_mode
);

    localparam logic [63:0] K_LIMIT = 64'd1 << CNT_W;

    if (K_10HZ < 1 || 64'(K_10HZ) > K_LIMIT ||
        K_1HZ  < 1 || 64'(K_1HZ)  > K_LIMIT ||
        K_0HZ1 < 1 || 64'(K_0HZ1) > K_LIMIT) begin : g_bad_modulus
        $error("blink_rate_controller: each K must satisfy 1 <= K <= 2**CNT_W");
    end

    localparam logic [CNT_W-1:0] KM1_10HZ = CNT_W'(K_10HZ - 1);
    localparam logic [CNT_W-1:0] KM1_1HZ  = CNT_W'(K_1HZ - 1);
    localparam logic [CNT_W-1:0] KM1_0HZ1 = CNT_W'(K_0HZ1 - 1);

    rate_mode_t       r_mode;
    rate_mode_t       w_mode_d;
    logic             w_step_pulse;
    logic             w_mode_change;
    logic [CNT_W-1:0] w_kmax;
    logic [CNT_W-1:0] r_count;
    logic             r_clk;
    logic             r_tick;

    step_sync_edge u_step_sync_edge (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_step    (i_step),
        .o_pulse   (w_step_pulse)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_mode <= rate_mode_t'(INIT_MODE);
        end else begin
            r_mode <= w_mode_d;
        end
    end

    // A load wins over a coincident step pulse; that pulse is simply dropped.
    always_comb begin
        w_mode_d = r_mode;
        if (i_mode_load) begin
            w_mode_d = rate_mode_t'(i_mode_val);
        end else if (w_step_pulse) begin
            w_mode_d = next_mode(r_mode);
        end
    end

    always_comb begin
        o_mode        = r_mode;
        w_mode_change = i_mode_load | w_step_pulse;
        w_kmax        = '0;
        unique case (r_mode)
            MODE_OFF:  w_kmax = '0;
            MODE_10HZ: w_kmax = KM1_10HZ;
            MODE_1HZ:  w_kmax = KM1_1HZ;
            MODE_0HZ1: w_kmax = KM1_0HZ1;
        endcase
    end

    // Any mode change restarts the phase, even while paused.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count <= '0;
            r_clk   <= 1'b0;
            r_tick  <= 1'b0;
        end else if (w_mode_change || r_mode == MODE_OFF) begin
            r_count <= '0;
            r_clk   <= 1'b0;
            r_tick  <= 1'b0;
        end else if (i_pause) begin
            r_tick  <= 1'b0;
        end else if (r_count == w_kmax) begin
            r_count <= '0;
            r_clk   <= ~r_clk;
            r_tick  <= 1'b1;
        end else begin
            r_count <= r_count + 1'b1;
            r_tick  <= 1'b0;
        end
    end

    assign o_clk  = r_clk;
    assign o_tick = r_tick;

endmodule
